// File: rtl/block_transfer_engine.sv
// Block transfer engine: moves a BLK_W x BLK_H block between an SRAM (16-bit words,
// RD_LAT-cycle read latency) and a DPRAM (32-bit words, 1-cycle read latency).
//   FETCH     (i_mode=0): SRAM words -> sign-extended -> DPRAM[dp_base + k]
//   WRITEBACK (i_mode=1): DPRAM words -> clipped to 0..255 -> packed pairs -> SRAM
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_start, i_mode               start request (IDLE only) and direction
//   i_base_address, i_row_stride  SRAM address of sample (0,0) and row pitch
//   i_dp_base                     DPRAM address of element (0,0)
//   o_busy, o_done                transfer in progress / one-cycle completion pulse
//   o_sram_*, i_sram_read_data    SRAM port (registered address, active-low write)
//   o_dp_*, i_dp_read_data        DPRAM port (registered address, write strobe)
module block_transfer_engine #(
  parameter int unsigned BLK_W  = 8,
  parameter int unsigned BLK_H  = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [17:0] i_base_address,
  input  logic [17:0] i_row_stride,
  input  logic [6:0]  i_dp_base,
  output logic        o_busy,
  output logic        o_done,
  output logic [17:0] o_sram_address,
  input  logic [15:0] i_sram_read_data,
  output logic [15:0] o_sram_write_data,
  output logic        o_sram_we_n,
  output logic [6:0]  o_dp_address,
  output logic [31:0] o_dp_write_data,
  output logic        o_dp_write_enable,
  input  logic [31:0] i_dp_read_data
);

  localparam int unsigned N     = BLK_W * BLK_H;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned COL_W = $clog2(BLK_W);

  localparam logic [CNT_W-1:0] LAST_K   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BLK_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetchIssue,
    StFetchDrain,
    StWbRun,
    StWbDrain,
    StDone
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [17:0]        r_stride;
  logic [6:0]         r_dp_base;
  // SRAM-side traversal: row start address plus column within the row
  logic [17:0]        r_row_addr;
  logic [COL_W-1:0]   r_col;
  // r_cnt_a counts issued addresses, r_cnt_b counts completed elements
  logic [CNT_W-1:0]   r_cnt_a;
  logic [CNT_W-1:0]   r_cnt_b;
  // High during each cycle an issued address is on the bus
  logic               r_iss;
  logic [RD_LAT-1:0]  r_rd_vld;
  logic               r_wb_vld;
  logic [7:0]         r_lo_pix;

  logic               r_busy;
  logic               r_done;
  logic [17:0]        r_sram_address;
  logic [15:0]        r_sram_write_data;
  logic               r_sram_we_n;
  logic [6:0]         r_dp_address;
  logic [31:0]        r_dp_write_data;
  logic               r_dp_we;

  logic [31:0]        w_sext;
  logic [7:0]         w_clip;
  logic               w_col_last;

  assign w_sext     = {{16{i_sram_read_data[15]}}, i_sram_read_data};
  // Signed clip to 0..255: negative -> 0, any bit above bit 7 set -> 255
  assign w_clip     = i_dp_read_data[31]      ? 8'h00 :
                      (|i_dp_read_data[30:8]) ? 8'hFF : i_dp_read_data[7:0];
  assign w_col_last = (r_col == LAST_COL);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= StIdle;
      r_mode            <= 1'b0;
      r_stride          <= '0;
      r_dp_base         <= '0;
      r_row_addr        <= '0;
      r_col             <= '0;
      r_cnt_a           <= '0;
      r_cnt_b           <= '0;
      r_iss             <= 1'b0;
      r_rd_vld          <= '0;
      r_wb_vld          <= 1'b0;
      r_lo_pix          <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_sram_address    <= '0;
      r_sram_write_data <= '0;
      r_sram_we_n       <= 1'b1;
      r_dp_address      <= '0;
      r_dp_write_data   <= '0;
      r_dp_we           <= 1'b0;
    end else begin
      r_sram_we_n <= 1'b1;
      r_dp_we     <= 1'b0;
      r_done      <= 1'b0;
      r_iss       <= 1'b0;

      // Read-valid tracking: fetch reads land RD_LAT cycles after the address cycle,
      // DPRAM reads land one cycle after it.
      r_rd_vld[0] <= r_iss & ~r_mode;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
      end
      r_wb_vld <= r_iss & r_mode;

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_row_addr <= i_base_address;
            r_stride   <= i_row_stride;
            r_dp_base  <= i_dp_base;
            r_col      <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_busy     <= 1'b1;
            r_state    <= i_mode ? StWbRun : StFetchIssue;
          end
        end
        StFetchIssue: begin
          r_sram_address <= r_row_addr + 18'(r_col);
          r_iss          <= 1'b1;
          r_cnt_a        <= r_cnt_a + 1'b1;
          if (w_col_last) begin
            r_col      <= '0;
            r_row_addr <= r_row_addr + r_stride;
          end else begin
            r_col <= r_col + 1'b1;
          end
          if (r_cnt_a == LAST_K) r_state <= StFetchDrain;
        end
        StWbRun: begin
          r_dp_address <= r_dp_base + 7'(r_cnt_a);
          r_iss        <= 1'b1;
          r_cnt_a      <= r_cnt_a + 1'b1;
          if (r_cnt_a == LAST_K) r_state <= StWbDrain;
        end
        StFetchDrain, StWbDrain: begin
          // Done follows the cycle in which the last write was presented
          if (r_cnt_b == N_CNT) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      // FETCH completion: returned word goes to DPRAM in arrival order
      if (r_rd_vld[RD_LAT-1]) begin
        r_dp_we         <= 1'b1;
        r_dp_address    <= r_dp_base + 7'(r_cnt_b);
        r_dp_write_data <= w_sext;
        r_cnt_b         <= r_cnt_b + 1'b1;
      end

      // WRITEBACK completion: even element is held, odd element completes the pair
      if (r_wb_vld) begin
        if (!r_cnt_b[0]) begin
          r_lo_pix <= w_clip;
        end else begin
          r_sram_address    <= r_row_addr + 18'(r_col >> 1);
          r_sram_write_data <= {r_lo_pix, w_clip};
          r_sram_we_n       <= 1'b0;
        end
        r_cnt_b <= r_cnt_b + 1'b1;
        if (w_col_last) begin
          r_col      <= '0;
          r_row_addr <= r_row_addr + r_stride;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_sram_address    = r_sram_address;
  assign o_sram_write_data = r_sram_write_data;
  assign o_sram_we_n       = r_sram_we_n;
  assign o_dp_address      = r_dp_address;
  assign o_dp_write_data   = r_dp_write_data;
  assign o_dp_write_enable = r_dp_we;

endmodule
